// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: bundle geometry and the
// {pc, data} record held in the bundle queue.
package fetch_pkg;

  localparam int INST_W       = 32;
  localparam int LANES        = 4;
  localparam int BUNDLE_W     = INST_W * LANES;
  localparam int BUNDLE_BYTES = BUNDLE_W / 8;

  typedef struct packed {
    logic [31:0]         pc;
    logic [BUNDLE_W-1:0] data;
  } bundle_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small show-ahead synchronous FIFO with flush; used for the in-flight
// address list and for the bundle queue.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/bundle_fetch.sv
// Fetch stage: issues one imem read per cycle under a credit limit, queues
// in-order responses for decode, and discards stale responses after a squash.
module bundle_fetch
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc,
  input  logic                squash,
  output logic                pc_stall,
  output logic                imem_req_valid,
  output logic [31:0]         imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_resp_valid,
  input  logic [BUNDLE_W-1:0] imem_resp_data,
  output logic                bundle_valid,
  input  logic                bundle_ready,
  output logic [31:0]         bundle_pc,
  output logic [BUNDLE_W-1:0] bundle_data
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int QW = $clog2(DEPTH + 1);

  logic [CW-1:0] stale_reg, stale_next;
  logic [CW-1:0] live_reg, live_next;

  logic          issue;
  logic          resp_live;
  logic          credit_ok;

  logic [31:0]   af_head;
  logic [CW-1:0] af_count;
  logic          af_empty, af_full, af_pop;

  bundle_t       q_in, q_out;
  logic [QW-1:0] q_count;
  logic          q_empty, q_full, q_push, q_pop;

  logic          unused_af_full;
  assign unused_af_full = af_full;

  // Credit depends only on registered state, so bundle_ready never reaches pc_stall.
  assign credit_ok      = ((int'(q_count) + int'(live_reg)) < DEPTH) &&
                          (int'(af_count) < MAX_OUT);
  assign imem_req_valid = credit_ok && !rst;
  assign imem_req_addr  = pc;
  assign issue          = imem_req_valid && imem_req_ready;
  assign pc_stall       = !rst && !issue;

  assign resp_live = imem_resp_valid && (stale_reg == '0);
  assign af_pop    = imem_resp_valid && !af_empty;

  fetch_fifo #(.DEPTH(MAX_OUT), .WIDTH(32)) u_addr_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (issue),
    .push_data (pc),
    .pop       (af_pop),
    .pop_data  (af_head),
    .count     (af_count),
    .empty     (af_empty),
    .full      (af_full)
  );

  assign q_in.pc   = af_head;
  assign q_in.data = imem_resp_data;
  assign q_push    = resp_live && !squash && !q_full;
  assign q_pop     = bundle_valid && bundle_ready;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(bundle_t))) u_bundle_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (squash),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .pop_data  (q_out),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign bundle_valid = !q_empty && !squash;
  assign bundle_pc    = q_empty ? '0 : q_out.pc;
  assign bundle_data  = q_empty ? '0 : q_out.data;

  always_comb begin
    stale_next = stale_reg;
    live_next  = live_reg;
    if (squash) begin
      // Everything already outstanding becomes stale; only the target request is live.
      stale_next = af_count - CW'(imem_resp_valid);
      live_next  = CW'(issue);
    end else begin
      if (imem_resp_valid && (stale_reg != '0)) stale_next = stale_reg - CW'(1);
      live_next = live_reg + CW'(issue) - CW'(resp_live);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stale_reg <= '0;
      live_reg  <= '0;
    end else begin
      stale_reg <= stale_next;
      live_reg  <= live_next;
    end
  end

endmodule

// File: doc/bundle_fetch.md
Name: bundle_fetch

Overview:
- Fetch stage directly downstream of program_counter.
- Each cycle it takes the PC's 32-bit bundle address and issues a 128-bit read to instruction memory. In-order responses are buffered in a bundle queue and presented to the four decode lanes with a valid/ready handshake.
- Back-pressures the PC via pc_stall. Honours squash by flushing the queue and discarding responses still in flight.

Parameters:
- DEPTH, 4, bundle queue entries; also the credit limit on live requests.
- MAX_OUT, 4, maximum outstanding imem requests, live plus stale.
- BUNDLE_W, 128, bundle width: 4 instructions x 32 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc  in  32  current bundle address from program_counter
- squash  in  1  branch-redirect flush from program_counter
- pc_stall  out  1  holds program_counter when high
- imem_req_valid  out  1  read request
- imem_req_addr  out  32  read address, equal to pc
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_resp_valid  in  1  read data valid; responses return in order, at most 1 per cycle
- imem_resp_data  in  BUNDLE_W  read data
- bundle_valid  out  1  head bundle valid to decode
- bundle_ready  in  1  decode consumes the head bundle
- bundle_pc  out  32  address of the head bundle
- bundle_data  out  BUNDLE_W  head bundle; bits [32k+31:32k] go to lane k

Behaviour:
- Reset: queue empty; live, stale and in-flight counters 0; bundle_valid=0, imem_req_valid=0, pc_stall=0.
  - bundle_pc and bundle_data are 0 while empty.
  - Reset mid-operation discards everything. The memory is also reset, so no pre-reset responses arrive.
- Credit:
  - live = queue count + live in-flight requests.
  - credit_ok = (live < DEPTH) && (total in-flight < MAX_OUT).
  - All terms come from registered counters. There is no combinational path from bundle_ready to pc_stall; a pop frees credit on the next cycle.
- Request: imem_req_valid = credit_ok && !rst. imem_req_addr = pc.
  - A request is issued when imem_req_valid && imem_req_ready. Its pc is pushed into the in-flight address FIFO in the same cycle.
- pc_stall = !(imem_req_valid && imem_req_ready). PC advances 16 B only when a request issued.
- Response:
  - If stale > 0: drop the response, stale--, pop its address entry.
  - Otherwise push {addr, data} into the bundle queue. Credit guarantees the queue is never full at push.
  - A pushed bundle is visible on bundle_valid the next cycle (1-cycle queue latency, no bypass).
- Output: bundle_valid = !empty && !squash. Pop on bundle_valid && bundle_ready.
- Squash cycle, all updates in the same edge:
  - The queue is flushed.
  - Any response arriving this cycle is dropped.
  - stale = in-flight requests excluding this cycle's new request and excluding any response returning this cycle.
  - Live in-flight is set to 0. Any pop is suppressed.
  - The request for pc (the branch target) is still issued if credit allows, and counts as live.
- Squash held over several cycles (PC stalled): each cycle re-flushes. This is harmless because no target request issued on the earlier cycles.
- Simultaneous push and pop: count unchanged. Simultaneous issue and response: in-flight unchanged.
- Counters are sized clog2(MAX_OUT+1). Addresses are not incremented in this block; no wrap logic.

Decomposition:
- Package fetch_pkg: BUNDLE_W, INST_W=32, LANES=4, BUNDLE_BYTES=16, bundle_t struct {pc[31:0], data[BUNDLE_W-1:0]}.
- Sub-module fetch_fifo: parameterised synchronous FIFO with push, pop, flush, count, empty and full. Instantiated twice: in-flight address FIFO (depth MAX_OUT, width 32) and bundle queue (depth DEPTH, bundle_t).

Test Plan:
1. Reset, then pc=0x00400020, imem ready, 1-cycle response latency, bundle_ready=1 → requests at 0x00400020, 0x00400030, ... every cycle. First bundle_valid arrives 2 cycles after the first request, with bundle_pc=0x00400020 and lane 0..3 data intact; pc_stall stays 0.
2. bundle_ready=0 with a steady stream → after 4 live requests pc_stall=1, queue holds 4. Raise bundle_ready → one pop per cycle; pc_stall drops 1 cycle after the first pop.
3. imem_req_ready=0 for 3 cycles → pc_stall=1 for those cycles; no request issued; in-flight unchanged.
4. 3-cycle memory latency, 2 requests in flight, 2 bundles queued, then squash with pc=0x00400100 → queue empty and bundle_valid=0 that cycle. The 2 stale responses are dropped; the first bundle out is 0x00400100.
5. Squash held 3 cycles with imem_req_ready=0 → exactly one request for the target after release; no duplicate or lost bundle.
6. Assert rst mid-stream with a full queue → next cycle all outputs are at reset values and counters are 0.
